// File: rtl/device_monitor_n.sv
// Per-channel saturating up/down device counters with sticky saturation flags,
// a registered channel total, and a hysteresis alarm driven from that total.
module device_monitor_n #(
  parameter int WIDTH     = 8,
  parameter int NUM_CH    = 4,
  parameter int HI_THRESH = 16,
  parameter int LO_THRESH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       change,
  input  logic [NUM_CH-1:0]       on_off,
  input  logic                    flag_clr,
  output logic [NUM_CH*WIDTH-1:0] count_bus,
  output logic [WIDTH+3:0]        total_out,
  output logic                    alarm,
  output logic [NUM_CH-1:0]       sat_hi,
  output logic [NUM_CH-1:0]       sat_lo
);

  localparam logic [WIDTH-1:0] MAX_CNT = '1;
  localparam logic [WIDTH-1:0] ONE_CNT = WIDTH'(1);
  localparam logic [WIDTH+3:0] HI_LVL  = (WIDTH+4)'(HI_THRESH);
  localparam logic [WIDTH+3:0] LO_LVL  = (WIDTH+4)'(LO_THRESH);

  typedef enum logic {NORMAL, ALARM} state_t;

  logic [WIDTH-1:0] r_count [NUM_CH];
  logic [WIDTH-1:0] w_next  [NUM_CH];
  logic [NUM_CH-1:0] r_satHi, r_satLo;
  logic [NUM_CH-1:0] w_upSat, w_dnSat;
  logic [WIDTH+3:0] r_total, w_sum;
  state_t r_state, w_nextState;

  always_comb begin
    w_upSat = '0;
    w_dnSat = '0;
    w_sum   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_next[i] = r_count[i];
      if (change[i]) begin
        if (on_off[i]) begin
          if (r_count[i] == MAX_CNT) w_upSat[i] = 1'b1;
          else                       w_next[i]  = r_count[i] + ONE_CNT;
        end else begin
          if (r_count[i] == '0) w_dnSat[i] = 1'b1;
          else                  w_next[i]  = r_count[i] - ONE_CNT;
        end
      end
      w_sum = w_sum + (WIDTH+4)'(r_count[i]);
    end
  end

  // The total sums the current registered counts, so it trails count_bus by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) r_count[i] <= '0;
      r_satHi <= '0;
      r_satLo <= '0;
      r_total <= '0;
      r_state <= NORMAL;
    end else begin
      for (int i = 0; i < NUM_CH; i++) r_count[i] <= w_next[i];
      r_satHi <= (r_satHi & ~{NUM_CH{flag_clr}}) | w_upSat;
      r_satLo <= (r_satLo & ~{NUM_CH{flag_clr}}) | w_dnSat;
      r_total <= w_sum;
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      NORMAL:  if (r_total >= HI_LVL) w_nextState = ALARM;
      ALARM:   if (r_total <= LO_LVL) w_nextState = NORMAL;
      default: w_nextState = NORMAL;
    endcase
  end

  always_comb begin
    count_bus = '0;
    for (int i = 0; i < NUM_CH; i++) count_bus[i*WIDTH +: WIDTH] = r_count[i];
  end

  assign total_out = r_total;
  assign alarm     = (r_state == ALARM);
  assign sat_hi    = r_satHi;
  assign sat_lo    = r_satLo;

endmodule

// File: tb/tb_device_monitor_n.sv
// Directed bench for device_monitor_n: hand-computed expectations checked
// with immediate assertions after each clock edge.
module tb_device_monitor_n;

  logic        clk;
  logic        rst;
  logic [3:0]  change;
  logic [3:0]  on_off;
  logic        flag_clr;
  logic [31:0] count_bus;
  logic [11:0] total_out;
  logic        alarm;
  logic [3:0]  sat_hi;
  logic [3:0]  sat_lo;

  int vectors;
  int miscompares;

  device_monitor_n #(.WIDTH(8), .NUM_CH(4), .HI_THRESH(16), .LO_THRESH(8)) dut (
    .clk(clk), .rst(rst), .change(change), .on_off(on_off), .flag_clr(flag_clr),
    .count_bus(count_bus), .total_out(total_out), .alarm(alarm),
    .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [3:0] ch, input logic [3:0] dir,
                               input logic clr, input int cycles);
    rst = r; change = ch; on_off = dir; flag_clr = clr;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] expBus, input logic [11:0] expTot,
                          input logic expAlarm, input logic [3:0] expHi, input logic [3:0] expLo);
    checkOutput({tag, ".count_bus"}, count_bus, expBus);
    checkOutput({tag, ".total_out"}, 32'(total_out), 32'(expTot));
    checkOutput({tag, ".alarm"}, 32'(alarm), 32'(expAlarm));
    checkOutput({tag, ".sat_hi"}, 32'(sat_hi), 32'(expHi));
    checkOutput({tag, ".sat_lo"}, 32'(sat_lo), 32'(expLo));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; change = '0; on_off = '0; flag_clr = 1'b0;

    // Reset held with every channel requesting up-counts
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 4'hF, 4'hF, 1'b0, 1);
      checkAll("reset_hold", 32'h0, 12'd0, 1'b0, 4'h0, 4'h0);
    end

    // Channel 0 up five times, then total catches up a cycle later
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b0, 5);
    checkAll("ch0_up5", 32'h0000_0005, 12'd4, 1'b0, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'b0000, 4'b0001, 1'b0, 1);
    checkAll("ch0_total", 32'h0000_0005, 12'd5, 1'b0, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b0, 2);
    checkAll("ch0_down2", 32'h0000_0003, 12'd4, 1'b0, 4'h0, 4'h0);

    // Channel 1 underflow attempts, then flag clear
    applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b0, 3);
    checkAll("ch1_satlo", 32'h0000_0003, 12'd3, 1'b0, 4'h0, 4'b0010);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 1);
    checkAll("ch1_clrlo", 32'h0000_0003, 12'd3, 1'b0, 4'h0, 4'h0);

    // Channel 1 to full scale and beyond
    applyStimulus(1'b0, 4'b0010, 4'b0010, 1'b0, 255);
    checkOutput("ch1_full.count_bus", count_bus, 32'h0000_FF03);
    checkOutput("ch1_full.sat_hi", 32'(sat_hi), 32'h0);
    applyStimulus(1'b0, 4'b0010, 4'b0010, 1'b0, 2);
    checkAll("ch1_sathi", 32'h0000_FF03, 12'd258, 1'b1, 4'b0010, 4'h0);

    // Saturation event coincident with clear keeps the flag
    applyStimulus(1'b0, 4'b0010, 4'b0010, 1'b1, 1);
    checkOutput("set_wins.sat_hi", 32'(sat_hi), 32'b0010);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1, 1);
    checkAll("clr_hi", 32'h0000_FF03, 12'd258, 1'b1, 4'h0, 4'h0);

    // Set both flag kinds while alarmed, then a one-cycle reset
    applyStimulus(1'b0, 4'b0110, 4'b0010, 1'b0, 1);
    checkAll("pre_rst", 32'h0000_FF03, 12'd258, 1'b1, 4'b0010, 4'b0100);
    applyStimulus(1'b1, 4'hF, 4'hF, 1'b1, 1);
    checkAll("rst_pulse", 32'h0, 12'd0, 1'b0, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b0, 1);
    checkAll("resume_up", 32'h0000_0001, 12'd0, 1'b0, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b0, 1);
    checkAll("resume_dn", 32'h0, 12'd1, 1'b0, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 1);
    checkAll("resume_idle", 32'h0, 12'd0, 1'b0, 4'h0, 4'h0);

    // All channels up four times: sum 16 -> total 16 -> alarm
    applyStimulus(1'b0, 4'hF, 4'hF, 1'b0, 4);
    checkAll("all_up4", 32'h0404_0404, 12'd12, 1'b0, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1);
    checkAll("total16", 32'h0404_0404, 12'd16, 1'b0, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1);
    checkAll("alarm_on", 32'h0404_0404, 12'd16, 1'b1, 4'h0, 4'h0);

    // Down to sum 9: alarm holds inside the hysteresis band
    applyStimulus(1'b0, 4'hF, 4'h0, 1'b0, 1);
    applyStimulus(1'b0, 4'b0111, 4'h0, 1'b0, 1);
    checkOutput("sum9.count_bus", count_bus, 32'h0302_0202);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 3);
    checkAll("sum9_hold", 32'h0302_0202, 12'd9, 1'b1, 4'h0, 4'h0);

    // Sum 8 releases the alarm two edges later
    applyStimulus(1'b0, 4'b0001, 4'h0, 1'b0, 1);
    checkAll("sum8", 32'h0302_0201, 12'd9, 1'b1, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1);
    checkAll("total8", 32'h0302_0201, 12'd8, 1'b1, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1);
    checkAll("alarm_off", 32'h0302_0201, 12'd8, 1'b0, 4'h0, 4'h0);

    // Idle with direction toggling: nothing moves
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 4'h0, (k % 2 == 0) ? 4'hF : 4'h0, 1'b0, 1);
      checkAll("idle", 32'h0302_0201, 12'd8, 1'b0, 4'h0, 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
